// File: rtl/tinyalu_arbiter.sv
// rtl/tinyalu_arbiter.sv - round-robin arbiter sharing one TinyALU among N_REQ requesters
module tinyalu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_A,
    input  logic [8*N_REQ-1:0]   req_B,
    input  logic [3*N_REQ-1:0]   req_op,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [15:0]          rsp_result,
    output logic                 rsp_error,
    output logic [7:0]           alu_A,
    output logic [7:0]           alu_B,
    output logic [2:0]           alu_op,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [15:0]          alu_result,
    output logic                 busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_g;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [2:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_result;
    logic            r_err;

    logic            w_any;
    logic [PW-1:0]   w_gidx;
    logic [PW:0]     w_sum;
    logic [PW:0]     w_psum;
    logic [PW-1:0]   w_ptr_next;
    logic [PW+1:0]   w_op_base;
    logic [7:0]      w_a;
    logic [7:0]      w_b;
    logic [2:0]      w_op;
    logic            w_is_alu;
    logic            w_local_err;
    logic            w_timeout;

    // Scan from the highest offset down so the closest valid index at/after r_ptr wins.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_sum  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(N_REQ))
                w_sum = w_sum - (PW+1)'(N_REQ);
            if (req_valid[w_sum[PW-1:0]]) begin
                w_any  = 1'b1;
                w_gidx = w_sum[PW-1:0];
            end
        end
    end

    assign w_op_base   = {1'b0, w_gidx, 1'b0} + {2'b00, w_gidx};
    assign w_a         = req_A[{w_gidx, 3'b000} +: 8];
    assign w_b         = req_B[{w_gidx, 3'b000} +: 8];
    assign w_op        = req_op[w_op_base +: 3];
    assign w_is_alu    = (w_op != 3'd0) && (w_op <= 3'd4);
    assign w_local_err = (w_op >= 3'd5);
    assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));

    assign w_psum      = {1'b0, r_g} + (PW+1)'(1);
    assign w_ptr_next  = (w_psum == (PW+1)'(N_REQ)) ? '0 : w_psum[PW-1:0];

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_result = 16'h0000;
        rsp_error  = 1'b0;
        alu_A      = 8'h00;
        alu_B      = 8'h00;
        alu_op     = 3'b000;
        alu_start  = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any && !reset) begin
                    req_ready[w_gidx] = 1'b1;
                    w_next = w_is_alu ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                alu_start = 1'b1;
                alu_A     = r_a;
                alu_B     = r_b;
                alu_op    = r_op;
                if (alu_done || w_timeout)
                    w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid[r_g] = 1'b1;
                rsp_result     = r_result;
                rsp_error      = r_err;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Local ops settle result/error at accept; ALU ops overwrite them in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr    <= '0;
            r_g      <= '0;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_op     <= 3'b000;
            r_cnt    <= '0;
            r_result <= 16'h0000;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a      <= w_a;
                        r_b      <= w_b;
                        r_op     <= w_op;
                        r_g      <= w_gidx;
                        r_cnt    <= '0;
                        r_result <= 16'h0000;
                        r_err    <= w_local_err;
                    end
                end
                S_WAIT: begin
                    if (alu_done) begin
                        r_result <= alu_result;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= 16'h0000;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_ptr <= w_ptr_next;
                    r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
